// File: rtl/io_scan_pkg.sv
// rtl/io_scan_pkg.sv - sequencer states, device offsets and display nibble helper for io_scan_master
package io_scan_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD_SW,
    WR_LED,
    WR_DISP,
    RD_BTN,
    DONE
  } scan_state_e;

  localparam logic [7:0] OFF_SW    = 8'h00;
  localparam logic [7:0] OFF_BTN   = 8'h02;
  localparam logic [7:0] OFF_LED   = 8'h10;
  localparam logic [7:0] OFF_DISP  = 8'h20;
  localparam logic [7:0] OFF_DCTRL = 8'h24;
  localparam logic [7:0] OFF_IDLE  = 8'hFF;

  // Display digit idx (0 = leftmost) shows the matching switch nibble, MSB first.
  function automatic logic [3:0] disp_nibble(input logic [15:0] sw, input logic [1:0] idx);
    case (idx)
      2'd0:    return sw[15:12];
      2'd1:    return sw[11:8];
      2'd2:    return sw[7:4];
      default: return sw[3:0];
    endcase
  endfunction

endpackage

// File: rtl/io_scan_master_if.sv
// rtl/io_scan_master_if.sv - simple I/O device bus between io_scan_master and the device
interface io_scan_master_if;
  logic [15:0] addr;
  logic [15:0] data_out;
  logic [15:0] data_in;
  logic        we;

  modport master (output addr, output data_out, output we, input data_in);
  modport slave  (input addr, input data_out, input we, output data_in);
endinterface

// File: rtl/io_scan_master.sv
// rtl/io_scan_master.sv - periodic switch/button scanner driving LED and 4-digit display writes
// Define IO_SCAN_BTN_EN to add the button read and rising-edge detection to each scan.
module io_scan_master
  import io_scan_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] SCAN_DIV  = 16'd50000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  io_scan_master_if.master         bus,
  output logic                     busy,
  output logic [15:0]              sw_value,
  output logic [4:0]               btn_press,
  output logic                     scan_done
);

  localparam logic [15:0] IDLE_ADDR = {BASE_ADDR[15:8], OFF_IDLE};

  scan_state_e state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic [15:0] sw_q, sw_d;
  logic        done_q, done_d;
  logic        wrap;
`ifdef IO_SCAN_BTN_EN
  logic [4:0]  btn_prev_q, btn_prev_d;
  logic [4:0]  press_q, press_d;
`endif

  assign wrap = enable && (div_q == SCAN_DIV - 16'd1);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    addr_d  = IDLE_ADDR;
    data_d  = 16'h0000;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    sw_d    = sw_q;
    done_d  = 1'b0;
`ifdef IO_SCAN_BTN_EN
    btn_prev_d = btn_prev_q;
    press_d    = 5'b0;
`endif
    if (enable) begin
      div_d = wrap ? 16'd0 : div_q + 16'd1;
    end
    // Bus registers are loaded from the state being entered, so each state owns its bus cycle.
    case (state_q)
      INIT: begin
        state_d = IDLE;
        addr_d  = {BASE_ADDR[15:8], OFF_DCTRL};
        we_d    = 1'b1;
      end
      IDLE, DONE: begin
        state_d = IDLE;
        if (wrap) begin
          state_d = RD_SW;
          addr_d  = {BASE_ADDR[15:8], OFF_SW};
          busy_d  = 1'b1;
        end
      end
      RD_SW: begin
        sw_d    = bus.data_in;
        state_d = WR_LED;
        addr_d  = {BASE_ADDR[15:8], OFF_LED};
        data_d  = bus.data_in;
        we_d    = 1'b1;
        busy_d  = 1'b1;
      end
      WR_LED: begin
        state_d = WR_DISP;
        idx_d   = 2'd0;
        addr_d  = {BASE_ADDR[15:8], OFF_DISP};
        data_d  = {12'b0, disp_nibble(sw_q, 2'd0)};
        we_d    = 1'b1;
        busy_d  = 1'b1;
      end
      WR_DISP: begin
        if (idx_q != 2'd3) begin
          idx_d  = idx_q + 2'd1;
          addr_d = {BASE_ADDR[15:8], OFF_DISP | {6'b0, idx_d}};
          data_d = {12'b0, disp_nibble(sw_q, idx_d)};
          we_d   = 1'b1;
          busy_d = 1'b1;
        end else begin
`ifdef IO_SCAN_BTN_EN
          state_d = RD_BTN;
          addr_d  = {BASE_ADDR[15:8], OFF_BTN};
          busy_d  = 1'b1;
`else
          state_d = DONE;
          done_d  = 1'b1;
`endif
        end
      end
      RD_BTN: begin
`ifdef IO_SCAN_BTN_EN
        press_d    = bus.data_in[4:0] & ~btn_prev_q;
        btn_prev_d = bus.data_in[4:0];
        done_d     = 1'b1;
        state_d    = DONE;
`else
        state_d    = IDLE;
`endif
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      div_q   <= 16'd0;
      idx_q   <= 2'd0;
      addr_q  <= IDLE_ADDR;
      data_q  <= 16'h0000;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      sw_q    <= 16'h0000;
      done_q  <= 1'b0;
`ifdef IO_SCAN_BTN_EN
      btn_prev_q <= 5'b0;
      press_q    <= 5'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      sw_q    <= sw_d;
      done_q  <= done_d;
`ifdef IO_SCAN_BTN_EN
      btn_prev_q <= btn_prev_d;
      press_q    <= press_d;
`endif
    end
  end

  assign bus.addr     = addr_q;
  assign bus.data_out = data_q;
  assign bus.we       = we_q;
  assign busy         = busy_q;
  assign sw_value     = sw_q;
  assign scan_done    = done_q;
`ifdef IO_SCAN_BTN_EN
  assign btn_press    = press_q;
`else
  assign btn_press    = 5'b0;
`endif

endmodule
